// File: rtl/conv_pkg.sv
// conv_pkg: shared types and constants for the conv MAC arbiter slice.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        OUT
    } state_t;

    // Equals the datapath read + product pipeline depth.
    localparam int DRAIN_CYCLES = 2;

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin winner search from rr_ptr.
module rr_arbiter
    import conv_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int RW = width_of(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [RW-1:0]   rr_ptr,
    output logic [RW-1:0]   winner,
    output logic            any
);

    logic [RW-1:0] idx;

    // Walk from the farthest offset down so the nearest hit wins.
    always_comb begin
        winner = '0;
        any = 1'b0;
        idx = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            idx = RW'((int'(rr_ptr) + off) % NREQ);
            if (req_valid[idx]) begin
                winner = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_mac_arbiter.sv
// conv_mac_arbiter: round-robin sharing of one convolution MAC datapath.
module conv_mac_arbiter
    import conv_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int N = 128,
    parameter int M = 8,
    parameter int T = 16,
    localparam int LOGSIZE_N = width_of(N),
    localparam int LOGSIZE_M = width_of(M),
    localparam int LOGSIZE_R = width_of(NREQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*LOGSIZE_N-1:0] req_base,
    output logic [NREQ-1:0]           req_ready,
    output logic [LOGSIZE_N-1:0]      addr_x,
    output logic [LOGSIZE_M-1:0]      addr_f,
    output logic                      clear_acc,
    output logic                      en_acc,
    input  logic [T-1:0]              acc_data,
    output logic                      y_valid,
    output logic [T-1:0]              y_data,
    output logic [LOGSIZE_R-1:0]      y_id,
    input  logic                      y_ready,
    output logic                      busy
);

    state_t state, state_nx;

    logic [LOGSIZE_R-1:0] rr_ptr;
    logic [LOGSIZE_R-1:0] winner;
    logic [LOGSIZE_R-1:0] id;
    logic [LOGSIZE_N-1:0] base;
    logic [LOGSIZE_M-1:0] k;
    logic [1:0]           en_pipe;
    logic [1:0]           drain_cnt;
    logic                 any;
    logic                 issue;
    logic                 accept;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_rr (
        .req_valid(req_valid),
        .rr_ptr   (rr_ptr),
        .winner   (winner),
        .any      (any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id        <= '0;
            base      <= '0;
            k         <= '0;
            en_pipe   <= '0;
            drain_cnt <= '0;
        end else begin
            state   <= state_nx;
            en_pipe <= {en_pipe[0], issue};
            if (accept) begin
                id     <= winner;
                base   <= req_base[int'(winner)*LOGSIZE_N +: LOGSIZE_N];
                rr_ptr <= (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
            end
            unique case (state)
                CLEAR:   k <= LOGSIZE_M'(1);
                RUN:     k <= k + 1'b1;
                default: k <= '0;
            endcase
            drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        addr_x    = '0;
        addr_f    = '0;
        clear_acc = 1'b0;
        issue     = 1'b0;
        accept    = 1'b0;
        y_valid   = 1'b0;
        y_data    = '0;
        y_id      = '0;
        unique case (state)
            IDLE: begin
                if (any && !reset) begin
                    accept = 1'b1;
                    req_ready[winner] = 1'b1;
                    state_nx = CLEAR;
                end
            end
            CLEAR: begin
                clear_acc = 1'b1;
                issue = 1'b1;
                addr_x = base;
                state_nx = (M == 1) ? DRAIN : RUN;
            end
            RUN: begin
                issue = 1'b1;
                addr_x = base + LOGSIZE_N'(k);
                addr_f = k;
                if (int'(k) == M - 1) state_nx = DRAIN;
            end
            DRAIN: begin
                if (int'(drain_cnt) == DRAIN_CYCLES - 1) state_nx = OUT;
            end
            OUT: begin
                y_valid = 1'b1;
                y_data = acc_data;
                y_id = id;
                if (y_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign en_acc = en_pipe[1];
    assign busy = (state != IDLE);

endmodule

// File: doc/conv_mac_arbiter.md
Name: conv_mac_arbiter

Overview:
Shares one convolution MAC datapath among NREQ requesters. The datapath is an x memory with synchronous read, the filter ROM, a saturating product register, and a clear/enable accumulator with ReLU output. Each requester submits a dot-product job, identified by a base x address, and the block arbitrates round-robin. For the winner it sequences the datapath: addresses, accumulator clear and accumulator enable, aligned to the two-cycle read and product pipeline. It then returns the ReLU'd sum with the requester id on a valid/ready output.

Parameters:
NREQ, 4, number of requesters (≥2)
N, 128, x memory depth; LOGSIZE_N = $clog2(N)
M, 8, filter length / terms per job; LOGSIZE_M = $clog2(M)
T, 16, data width
LOGSIZE_R, localparam = max(1, $clog2(NREQ)), id width

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
req_valid  in  NREQ  job request per requester
req_base  in  NREQ*LOGSIZE_N  packed base x addresses; requester i occupies bits [i*LOGSIZE_N +: LOGSIZE_N]
req_ready  out  NREQ  one-hot job accept
addr_x  out  LOGSIZE_N  datapath x memory address
addr_f  out  LOGSIZE_M  datapath filter ROM address
clear_acc  out  1  datapath accumulator clear
en_acc  out  1  datapath accumulator enable
acc_data  in  T  datapath y_data (saturated, ReLU'd accumulator)
y_valid  out  1  result valid
y_data  out  T  result value
y_id  out  LOGSIZE_R  index of the requester that owns the result
y_ready  in  1  downstream ready
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=0, k=0, en pipe=0.
  - req_ready=0, clear_acc=0, en_acc=0, y_valid=0, busy=0, addr_x=0, addr_f=0.
- States: IDLE, CLEAR, RUN, DRAIN, OUT.
- IDLE:
  - Winner is the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping.
  - req_ready[winner]=1 in this cycle only (combinational on req_valid, one-hot). Handshake completes this cycle.
  - Latch id=winner and base=req_base[winner]; set rr_ptr<=(winner+1) mod NREQ; go to CLEAR.
  - With no req_valid, stay in IDLE with all req_ready=0.
- CLEAR (issue cycle t0):
  - clear_acc=1, addr_x=base, addr_f=0; k<=1; go to RUN.
- RUN:
  - addr_x=base+k (mod 2^LOGSIZE_N, no bounds check), addr_f=k, k<=k+1.
  - When k==M-1, go to DRAIN. For M=1, CLEAR goes directly to DRAIN.
- Issue flag:
  - issue = (state==CLEAR || state==RUN).
  - en_acc = issue delayed by exactly 2 cycles through a 2-bit shift register, so en_acc is high t0+2 .. t0+M+1.
- DRAIN:
  - Lasts 2 cycles (2-bit counter). addr_x/addr_f hold 0; then go to OUT.
  - The en pipe drains during these cycles.
- OUT:
  - y_valid=1, y_data=acc_data, y_id=id.
  - On y_ready=1, go to IDLE; otherwise hold, with y_data stable because the accumulator is not enabled.
- Latency:
  - Accept in cycle c → y_valid first high in cycle c+M+3.
  - Minimum spacing between accepts is M+4 cycles with y_ready tied high.
- addr_x/addr_f are 0 outside CLEAR and RUN. clear_acc is high only in CLEAR.
- Requests are only accepted in IDLE. req_valid may drop while not granted; the block holds no queue.
- Fairness: a continuously requesting requester waits at most NREQ-1 jobs.
- A y_ready high before OUT has no effect. Changes to req_base after accept are ignored.
- Reset mid-job: next cycle state=IDLE, en pipe cleared, no y_valid, in-flight result discarded, rr_ptr=0.

Decomposition:
- Package conv_pkg: state enum (IDLE, CLEAR, RUN, DRAIN, OUT) and the DRAIN_CYCLES=2 constant, matching the datapath read + product pipeline depth.
- Sub-module rr_arbiter #(NREQ): combinational winner/any outputs from req_valid and rr_ptr. The pointer register stays in the parent.

Test Plan:
- Single job, M=8: only req 2 valid, base=5 → req_ready=4'b0100 in the accept cycle; addr_x 5..12 and addr_f 0..7 on consecutive cycles; clear_acc one cycle; en_acc 8 cycles starting 2 after clear_acc; y_valid at c+11 with y_id=2 and y_data equal to the datapath ReLU result.
- Round-robin: all four req_valid held high, y_ready=1 → grant order 0,1,2,3,0; every accept spaced 12 cycles.
- Backpressure: y_ready=0 for 20 cycles in OUT → y_valid, y_data and y_id stable, busy=1, no req_ready; y_ready=1 → IDLE, next grant the cycle after.
- Reset mid-RUN (k=4) → next cycle all outputs 0, state IDLE, rr_ptr=0; a fresh job then completes normally.
- Boundary: base=N-M=120 → last addr_x=127. Separately, M=1 configuration → en_acc exactly 1 cycle and y_valid at c+4.
- Pointer wrap: req 3 granted, then only req 0 valid → req 0 granted immediately, rr_ptr=1.
